// File: rtl/line_reader_76_if.sv
// line_reader_76_if
// Bundles the buffer read port, the writer-side flow signals and the
// downstream column handshake of line_reader_76.
//   master : reader side (drives rd_en, rd_addr, col_*, out_valid, consume)
//   slave  : buffer/downstream side (drives enable, words_avail, rd_data,
//            out_ready)
interface line_reader_76_if;
    logic        enable;
    logic [6:0]  words_avail;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] col_top;
    logic [31:0] col_mid;
    logic [31:0] col_bot;
    logic        out_valid;
    logic        out_ready;
    logic        consume;

    modport master (
        input  enable, words_avail, rd_data, out_ready,
        output rd_en, rd_addr, col_top, col_mid, col_bot, out_valid, consume
    );

    modport slave (
        output enable, words_avail, rd_data, out_ready,
        input  rd_en, rd_addr, col_top, col_mid, col_bot, out_valid, consume
    );
endinterface

// File: rtl/line_reader_76.sv
// line_reader_76
// Fetches a 3-pixel vertical column (base, base+LINE_W, base+2*LINE_W, all
// modulo DEPTH) from a circular line buffer with a synchronous read port,
// presents it downstream with a valid/ready handshake, then advances base by
// one word and pulses consume to hand that word back to the writer.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        line_reader_76_if.master (enable, words_avail, rd_en, rd_addr,
//              rd_data, col_top/mid/bot, out_valid, out_ready, consume)
//   col_count  (only with LINE_READER_STATS_EN) saturating count of columns
//              accepted downstream
// Optional feature macro: LINE_READER_STATS_EN
module line_reader_76 #(
    parameter int DEPTH  = 76,
    parameter int LINE_W = 24
) (
    input  logic clk,
    input  logic rst_n,
    line_reader_76_if.master bus
`ifdef LINE_READER_STATS_EN
    ,
    output logic [15:0] col_count
`endif
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_TOP   = 3'd1;
    localparam logic [2:0] RD_MID   = 3'd2;
    localparam logic [2:0] RD_BOT   = 3'd3;
    localparam logic [2:0] WAIT_BOT = 3'd4;
    localparam logic [2:0] HOLD     = 3'd5;

    // Offsets are pre-reduced so a single conditional subtract wraps them.
    localparam logic [7:0] OFF_MID = 8'(LINE_W % DEPTH);
    localparam logic [7:0] OFF_BOT = 8'((2 * LINE_W) % DEPTH);
    localparam logic [7:0] DEPTH_8 = 8'(DEPTH);
    localparam int         NEED    = 2 * LINE_W + 1;

    logic [2:0] state;
    logic [6:0] base;
    logic [6:0] addr_hold;
    logic       avail_ok;

    function automatic logic [6:0] wrap_add(input logic [6:0] a, input logic [7:0] off);
        logic [7:0] s;
        s = {1'b0, a} + off;
        return (s >= DEPTH_8) ? 7'(s - DEPTH_8) : 7'(s);
    endfunction

    assign avail_ok      = int'(bus.words_avail) >= NEED;
    assign bus.out_valid = (state == HOLD);

    // Address is driven straight from base in the read states and otherwise
    // replays the last presented value from addr_hold.
    always_comb begin
        bus.rd_en   = 1'b0;
        bus.rd_addr = addr_hold;
        case (state)
            RD_TOP: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = base;
            end
            RD_MID: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = wrap_add(base, OFF_MID);
            end
            RD_BOT: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = wrap_add(base, OFF_BOT);
            end
            default: ;
        endcase
    end

    // rd_data lags rd_addr by one cycle, so each pixel is captured on the
    // edge leaving the state after the one that addressed it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= '0;
            addr_hold   <= '0;
            bus.col_top <= '0;
            bus.col_mid <= '0;
            bus.col_bot <= '0;
            bus.consume <= 1'b0;
        end else begin
            addr_hold   <= bus.rd_addr;
            bus.consume <= 1'b0;
            case (state)
                IDLE:     if (bus.enable && avail_ok) state <= RD_TOP;
                RD_TOP:   state <= RD_MID;
                RD_MID: begin
                    bus.col_top <= bus.rd_data;
                    state       <= RD_BOT;
                end
                RD_BOT: begin
                    bus.col_mid <= bus.rd_data;
                    state       <= WAIT_BOT;
                end
                WAIT_BOT: begin
                    bus.col_bot <= bus.rd_data;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        base        <= wrap_add(base, 8'd1);
                        bus.consume <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default:  state <= IDLE;
            endcase
        end
    end

`ifdef LINE_READER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_count <= '0;
        end else if (state == HOLD && bus.out_ready && col_count != 16'hFFFF) begin
            col_count <= col_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/line_reader_76.md
LINE_READER_76 -- requirements
Module: line_reader_76

Interface
REQ-001 Parameter DEPTH, default 76: number of 32-bit words in the circular line buffer being read.
REQ-002 Parameter LINE_W, default 24: stride in words between vertically adjacent pixels (one image line).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  permits a new column fetch to start; sampled only in IDLE.
REQ-006 words_avail  input  7  count of valid unread words in the buffer, supplied by the writer side.
REQ-007 rd_en  output  1  read strobe to the buffer's synchronous read port.
REQ-008 rd_addr  output  7  read address, always in range 0..DEPTH-1.
REQ-009 rd_data  input  32  buffer read data, valid the cycle after rd_en/rd_addr are presented.
REQ-010 col_top, col_mid, col_bot  output  32 each  3-pixel vertical column for the downstream edge kernel.
REQ-011 out_valid  output  1  column outputs valid.
REQ-012 out_ready  input  1  downstream accepts the column.
REQ-013 consume  output  1  one-cycle pulse releasing one word back to the writer side.

Function
REQ-014 The block SHALL implement states IDLE, RD_TOP, RD_MID, RD_BOT, WAIT_BOT and HOLD, with register base (0..DEPTH-1) holding the current column address.
REQ-015 IDLE -> RD_TOP when enable=1 and words_avail >= 2*LINE_W+1 (49 by default); otherwise the block SHALL remain in IDLE.
REQ-016 rd_en SHALL be 1 only in RD_TOP, RD_MID and RD_BOT, and 0 in all other states.
REQ-017 rd_addr SHALL be base in RD_TOP, (base+LINE_W) mod DEPTH in RD_MID, (base+2*LINE_W) mod DEPTH in RD_BOT, and hold its last value elsewhere.
REQ-018 Capture: col_top from rd_data at the edge leaving RD_MID, col_mid at the edge leaving RD_BOT, col_bot at the edge leaving WAIT_BOT.
REQ-019 RD_TOP -> RD_MID -> RD_BOT -> WAIT_BOT -> HOLD SHALL be taken unconditionally, one cycle each.
REQ-020 out_valid SHALL be 1 exactly while in HOLD, first asserted 4 cycles after the IDLE->RD_TOP edge.
REQ-021 In HOLD, col_* SHALL remain stable until out_valid and out_ready are both 1.
REQ-022 On the HOLD handshake edge: base <= (base+1) mod DEPTH, consume=1 for the following cycle only, and state returns to IDLE.
REQ-023 The column period with out_ready held at 1 SHALL be 6 cycles.
REQ-024 Deasserting enable mid-column SHALL NOT abort the column; the column completes through HOLD.
REQ-025 A change in words_avail outside IDLE SHALL have no effect.
REQ-026 base wrap: base = DEPTH-1 SHALL advance to 0; offsets SHALL wrap modulo DEPTH (e.g., base 30 gives bot address 2).

Reset
REQ-027 While rst_n=0: state=IDLE, base=0, rd_en=0, rd_addr=0, col_*=0, out_valid=0, consume=0.
REQ-028 Reset asserted in any state SHALL abandon the in-flight column with no consume pulse; after release, fetching restarts at base 0.

Configuration
REQ-029 Macro LINE_READER_STATS_EN: when defined, the block SHALL add output col_count (16 bits, reset 0), incremented on each HOLD handshake and saturating at 0xFFFF.
REQ-030 When LINE_READER_STATS_EN is undefined, col_count SHALL be absent and all other behaviour SHALL be identical.

Verification (buffer preloaded mem[i]=i)
REQ-031 Reset: hold rst_n=0 -> all outputs 0 and state IDLE; release with enable=0 -> outputs remain 0.
REQ-032 enable=1, words_avail=76, out_ready=1 -> out_valid 4 cycles after start with top=0, mid=24, bot=48; consume 1 cycle later; next column top=1, mid=25, bot=49 arrives 6 cycles after the first.
REQ-033 Wrap: run 30 columns -> column 31 gives top=30, mid=54, bot=2; at base 75 -> top=75, mid=23, bot=47, then base returns to 0.
REQ-034 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid held, col_* stable, no consume; raising out_ready -> exactly one consume.
REQ-035 words_avail=48 -> rd_en never asserts; raising it to 49 -> RD_TOP on the next edge.
REQ-036 rst_n pulsed low in RD_MID -> no out_valid, no consume; after release, the first column is top=0 (with LINE_READER_STATS_EN, col_count=0).
